// File: rtl/cla_pkg.sv
// Shared constants and elaboration helpers for the pipelined CLA adder.
//   clog4       : number of gp4 tree levels needed to cover n bits
//   width_legal : WIDTH must be a power of 4 the tree supports (4, 16, 64)
//   S1..S3      : stage indices into the pipeline valid vector
package cla_pkg;

  localparam int unsigned NUM_STAGES = 3;
  localparam int unsigned S1 = 0;
  localparam int unsigned S2 = 1;
  localparam int unsigned S3 = 2;

  // Smallest r with 4**r >= n.
  function automatic int unsigned clog4(input int unsigned n);
    int unsigned r = 0;
    longint unsigned v = 1;
    while (v < 64'(n)) begin
      v = v * 4;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic bit width_legal(input int unsigned w);
    return (w == 4) || (w == 16) || (w == 64);
  endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder.
//   in_valid/in_ready   : operand beat handshake (a, b, cin, sub)
//   out_valid/out_ready : result handshake (sum, cout, ovf, gout, pout)
// master drives operands and consumes results; slave is the adder.
interface cla_pipe_adder_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             gout;
  logic             pout;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, gout, pout
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, gout, pout
  );

endinterface

// File: rtl/cla_tree.sv
// Combinational multi-level lookahead tree built from gp4 cells.
//   g, p : per-bit generate/propagate
//   c0   : carry into bit 0
//   c    : c[i] = carry into bit i, c[WIDTH] = carry out of the MSB
//   gout/pout : full-width group generate/propagate (independent of c0)
module cla_tree
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] p,
  input  logic             c0,
  output logic [WIDTH:0]   c,
  output logic             gout,
  output logic             pout
);

  localparam int unsigned LEVELS = clog4(WIDTH);

  // Level k reduces 4*CELLS group signals to CELLS; group carries
  // computed one level up come back down as each cell's cin.
  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int unsigned CELLS = WIDTH >> (2 * (k + 1));

    logic [4*CELLS-1:0] gin_l;
    logic [4*CELLS-1:0] pin_l;
    logic [4*CELLS-1:0] ci;
    logic [CELLS-1:0]   go;
    logic [CELLS-1:0]   po;
    logic [CELLS-1:0]   cc;

    if (k == 0) begin : g_leaf
      assign gin_l = g;
      assign pin_l = p;
    end else begin : g_node
      assign gin_l = g_lvl[k-1].go;
      assign pin_l = g_lvl[k-1].po;
    end

    if (k == LEVELS - 1) begin : g_root
      assign cc = c0;
    end else begin : g_inner
      assign cc = g_lvl[k+1].ci;
    end

    for (genvar i = 0; i < CELLS; i++) begin : g_cell
      gp4 u_gp4 (
        .gin  (gin_l[4*i +: 4]),
        .pin  (pin_l[4*i +: 4]),
        .cin  (cc[i]),
        .gout (go[i]),
        .pout (po[i]),
        .cout (ci[4*i+1 +: 3])
      );
      assign ci[4*i] = cc[i];
    end
  end

  assign gout = g_lvl[LEVELS-1].go[0];
  assign pout = g_lvl[LEVELS-1].po[0];
  assign c    = {gout | (pout & c0), g_lvl[0].ci};

endmodule

// File: rtl/gp4.sv
// 4-bit group generate/propagate cell with internal lookahead carries.
//   gin/pin : generate/propagate of the four children (bit 0 = LSB)
//   cin     : carry into the group
//   gout    : group generate, pout: group propagate
//   cout    : carries into children 1..3 (cout[0] -> child 1)
module gp4 (
  input  logic [3:0] gin,
  input  logic [3:0] pin,
  input  logic       cin,
  output logic       gout,
  output logic       pout,
  output logic [2:0] cout
);

  assign cout[0] = gin[0] | (pin[0] & cin);
  assign cout[1] = gin[1] | (pin[1] & gin[0]) | (pin[1] & pin[0] & cin);
  assign cout[2] = gin[2] | (pin[2] & gin[1]) | (pin[2] & pin[1] & gin[0])
                 | (pin[2] & pin[1] & pin[0] & cin);

  assign gout = gin[3] | (pin[3] & gin[2]) | (pin[3] & pin[2] & gin[1])
              | (pin[3] & pin[2] & pin[1] & gin[0]);
  assign pout = &pin;

endmodule

// File: rtl/cla_pipe_adder.sv
// Three-stage pipelined carry-lookahead adder/subtractor.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : slave side of cla_pipe_adder_if (operands in, results out)
// S1 forms per-bit g/p, S2 registers the tree carries, S3 registers the
// result. One global advance moves all stages; results hold under stall.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  cla_pipe_adder_if.slave      bus
);

  localparam int unsigned MSB = WIDTH - 1;

  if (!width_legal(WIDTH)) begin : g_bad_width
    $error("cla_pipe_adder: WIDTH must be 4, 16 or 64");
  end

  logic                  adv;
  logic [NUM_STAGES-1:0] vld;

  logic [WIDTH-1:0] b_eff;
  logic             c0_in;

  logic [WIDTH-1:0] s1_g;
  logic [WIDTH-1:0] s1_p;
  logic             s1_c0;
  logic             s1_a_msb;
  logic             s1_b_msb;

  logic [WIDTH:0]   tree_c;
  logic             tree_g;
  logic             tree_p;

  logic [WIDTH:0]   s2_c;
  logic [WIDTH-1:0] s2_p;
  logic             s2_gout;
  logic             s2_pout;
  logic             s2_a_msb;
  logic             s2_b_msb;

  logic [WIDTH-1:0] sum_nxt;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             gout_q;
  logic             pout_q;

  // Stall only when a result is waiting and downstream refuses it.
  assign adv          = !vld[S3] || bus.out_ready;
  assign bus.in_ready = adv;

  // Subtraction is a + ~b + 1; cin is overridden in that mode.
  assign b_eff = bus.sub ? ~bus.b : bus.b;
  assign c0_in = bus.sub | bus.cin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
    end else if (adv) begin
      vld[S1] <= bus.in_valid;
      vld[S2] <= vld[S1];
      vld[S3] <= vld[S2];
    end
  end

  // S1: per-bit generate/propagate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_g     <= '0;
      s1_p     <= '0;
      s1_c0    <= 1'b0;
      s1_a_msb <= 1'b0;
      s1_b_msb <= 1'b0;
    end else if (adv && bus.in_valid) begin
      s1_g     <= bus.a & b_eff;
      s1_p     <= bus.a ^ b_eff;
      s1_c0    <= c0_in;
      s1_a_msb <= bus.a[MSB];
      s1_b_msb <= b_eff[MSB];
    end
  end

  cla_tree #(
    .WIDTH (WIDTH)
  ) u_tree (
    .g    (s1_g),
    .p    (s1_p),
    .c0   (s1_c0),
    .c    (tree_c),
    .gout (tree_g),
    .pout (tree_p)
  );

  // S2: carry vector from the lookahead tree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_c     <= '0;
      s2_p     <= '0;
      s2_gout  <= 1'b0;
      s2_pout  <= 1'b0;
      s2_a_msb <= 1'b0;
      s2_b_msb <= 1'b0;
    end else if (adv && vld[S1]) begin
      s2_c     <= tree_c;
      s2_p     <= s1_p;
      s2_gout  <= tree_g;
      s2_pout  <= tree_p;
      s2_a_msb <= s1_a_msb;
      s2_b_msb <= s1_b_msb;
    end
  end

  assign sum_nxt = s2_p ^ s2_c[WIDTH-1:0];

  // S3: result registers; bubbles leave the last result in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      gout_q <= 1'b0;
      pout_q <= 1'b0;
    end else if (adv && vld[S2]) begin
      sum_q  <= sum_nxt;
      cout_q <= s2_c[WIDTH];
      ovf_q  <= (s2_a_msb == s2_b_msb) && (sum_nxt[MSB] != s2_a_msb);
      gout_q <= s2_gout;
      pout_q <= s2_pout;
    end
  end

  assign bus.out_valid = vld[S3];
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.gout      = gout_q;
  assign bus.pout      = pout_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder at WIDTH 16 (main), 4 and 64.
module tb_cla_pipe_adder;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_out = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cla_pipe_adder_if #(.WIDTH(16)) b16 ();
  cla_pipe_adder_if #(.WIDTH(4))  b4 ();
  cla_pipe_adder_if #(.WIDTH(64)) b64 ();

  cla_pipe_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
  cla_pipe_adder #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(b4));
  cla_pipe_adder #(.WIDTH(64)) dut64 (.clk(clk), .rst(rst), .bus(b64));

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        gout;
    logic        pout;
    logic        chk_lat;
    int          acc_cyc;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] s, input logic co, ov, g, p);
    exp_t e;
    e.sum = s; e.cout = co; e.ovf = ov; e.gout = g; e.pout = p;
    e.chk_lat = 1'b1; e.acc_cyc = 0;
    return e;
  endfunction

  // Behavioural reference for random operands.
  function automatic exp_t model16(input logic [15:0] a, b, input logic cin, sub);
    logic [15:0] be;
    logic [16:0] full;
    logic [16:0] raw;
    be   = sub ? ~b : b;
    raw  = {1'b0, a} + {1'b0, be};
    full = raw + 17'(sub ? 1'b1 : cin);
    return mk(full[15:0], full[16], (a[15] == be[15]) && (full[15] != a[15]),
              raw[16], &(a ^ be));
  endfunction

  task automatic push16(input logic [15:0] a, b, input logic cin, sub, input exp_t e);
    bit ok = 1'b0;
    b16.in_valid = 1'b1;
    b16.a = a; b16.b = b; b16.cin = cin; b16.sub = sub;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = b16.in_ready;
      if (ok) begin
        e.acc_cyc = cyc;
        exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    if (!ok) check("push_accept_timeout", 64'(ok), 64'(1));
    b16.in_valid = 1'b0;
  endtask

  task automatic wait_outs(input int n);
    for (int t = 0; t < 200 && n_out < n; t++) @(negedge clk);
    check("result_count", 64'(n_out), 64'(n));
  endtask

  task automatic narrow_wide_beat(input logic [3:0] a4, bb4, input logic sub4,
                                  input logic [3:0] s4, input logic [3:0] f4,
                                  input logic [63:0] a64, bb64,
                                  input logic [63:0] s64, input logic [3:0] f64);
    int  acc;
    bit  got4 = 1'b0;
    bit  got64 = 1'b0;
    @(posedge clk); #1;
    b4.in_valid = 1'b1;  b4.a = a4;   b4.b = bb4;   b4.cin = 1'b0; b4.sub = sub4;
    b64.in_valid = 1'b1; b64.a = a64; b64.b = bb64; b64.cin = 1'b0; b64.sub = 1'b0;
    @(negedge clk);
    acc = cyc;
    check("w4_in_ready", 64'(b4.in_ready), 64'(1));
    check("w64_in_ready", 64'(b64.in_ready), 64'(1));
    @(posedge clk); #1;
    b4.in_valid = 1'b0;
    b64.in_valid = 1'b0;
    for (int t = 0; t < 20 && !(got4 && got64); t++) begin
      @(negedge clk);
      if (b4.out_valid && !got4) begin
        got4 = 1'b1;
        check("w4_sum", 64'(b4.sum), 64'(s4));
        check("w4_flags", 64'({b4.cout, b4.ovf, b4.gout, b4.pout}), 64'(f4));
        check("w4_latency", 64'(cyc - acc), 64'(3));
      end
      if (b64.out_valid && !got64) begin
        got64 = 1'b1;
        check("w64_sum", b64.sum, s64);
        check("w64_flags", 64'({b64.cout, b64.ovf, b64.gout, b64.pout}), 64'(f64));
        check("w64_latency", 64'(cyc - acc), 64'(3));
      end
    end
    check("w4_result_seen", 64'(got4), 64'(1));
    check("w64_result_seen", 64'(got64), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] sa[4];
    logic [15:0] sb[4];
    logic        ssub[4];
    exp_t        s_exp[4];
    bit          seen;
    bit          stale;
    int          base;

    rst = 1'b1;
    b16.in_valid = 1'b0; b16.a = '0; b16.b = '0; b16.cin = 1'b0; b16.sub = 1'b0; b16.out_ready = 1'b1;
    b4.in_valid = 1'b0;  b4.a = '0;  b4.b = '0;  b4.cin = 1'b0;  b4.sub = 1'b0;  b4.out_ready = 1'b1;
    b64.in_valid = 1'b0; b64.a = '0; b64.b = '0; b64.cin = 1'b0; b64.sub = 1'b0; b64.out_ready = 1'b1;

    // Result monitor: every consumed result must match the queue head.
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (b16.out_valid && b16.out_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious_out_valid", 64'(b16.out_valid), 64'(0));
          end else begin
            e = exp_q.pop_front();
            check("sum", 64'(b16.sum), 64'(e.sum));
            check("cout", 64'(b16.cout), 64'(e.cout));
            check("ovf", 64'(b16.ovf), 64'(e.ovf));
            check("gout", 64'(b16.gout), 64'(e.gout));
            check("pout", 64'(b16.pout), 64'(e.pout));
            if (e.chk_lat) check("latency", 64'(cyc - e.acc_cyc), 64'(3));
            n_out++;
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(b16.out_valid), 64'(0));
    check("rst_sum", 64'(b16.sum), 64'(0));
    check("rst_flags", 64'({b16.cout, b16.ovf, b16.gout, b16.pout}), 64'(0));
    check("rst_w4_out_valid", 64'(b4.out_valid), 64'(0));
    check("rst_w64_out_valid", 64'(b64.out_valid), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", 64'(b16.in_ready), 64'(1));
    @(posedge clk); #1;

    // Directed vectors, back to back.
    push16(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1, 0, 1, 0));
    push16(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 0, 1, 0, 0));
    push16(16'h1234, 16'h0000, 1'b1, 1'b0, mk(16'h1235, 0, 0, 0, 0));
    push16(16'h0005, 16'h0007, 1'b0, 1'b1, mk(16'hFFFE, 0, 0, 0, 0));
    push16(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1, 1, 1, 0));
    push16(16'h00FF, 16'hFF00, 1'b1, 1'b0, mk(16'h0000, 1, 0, 0, 1));
    push16(16'h1234, 16'h0000, 1'b1, 1'b1, mk(16'h1234, 1, 0, 1, 0));
    wait_outs(7);

    // Eight random back-to-back beats.
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      logic [15:0] ra, rb;
      logic        rc, rs;
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom);  rs = 1'($urandom);
      push16(ra, rb, rc, rs, model16(ra, rb, rc, rs));
    end
    wait_outs(15);

    // Backpressure: hold the first result for five cycles.
    sa[0] = 16'h0001; sb[0] = 16'h0001; ssub[0] = 1'b0;
    sa[1] = 16'h0002; sb[1] = 16'h0003; ssub[1] = 1'b0;
    sa[2] = 16'hFFFF; sb[2] = 16'hFFFF; ssub[2] = 1'b0;
    sa[3] = 16'h0010; sb[3] = 16'h0001; ssub[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_exp[i] = model16(sa[i], sb[i], 1'b0, ssub[i]);
      s_exp[i].chk_lat = 1'b0;
    end
    @(posedge clk); #1;
    b16.out_ready = 1'b0;
    fork
      for (int i = 0; i < 4; i++) push16(sa[i], sb[i], 1'b0, ssub[i], s_exp[i]);
    join_none
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      seen = b16.out_valid;
    end
    check("stall_first_valid", 64'(seen), 64'(1));
    for (int h = 0; h < 5; h++) begin
      if (h > 0) @(negedge clk);
      check("stall_in_ready", 64'(b16.in_ready), 64'(0));
      check("stall_out_valid", 64'(b16.out_valid), 64'(1));
      check("stall_sum", 64'(b16.sum), 64'(s_exp[0].sum));
      check("stall_cout", 64'(b16.cout), 64'(s_exp[0].cout));
    end
    @(posedge clk); #1;
    b16.out_ready = 1'b1;
    wait_outs(19);

    // Reset with beats in flight, one already at the output.
    @(posedge clk); #1;
    push16(16'h1111, 16'h2222, 1'b0, 1'b0, mk(16'h3333, 0, 0, 0, 0));
    push16(16'h4444, 16'h1111, 1'b0, 1'b0, mk(16'h5555, 0, 0, 0, 0));
    push16(16'h0100, 16'h0001, 1'b0, 1'b1, mk(16'h00FF, 1, 0, 1, 0));
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("flush_out_valid", 64'(b16.out_valid), 64'(0));
    check("flush_sum", 64'(b16.sum), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    stale = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (b16.out_valid) stale = 1'b1;
    end
    check("flush_no_stale", 64'(stale), 64'(0));
    base = n_out;
    @(posedge clk); #1;
    push16(16'h0001, 16'h0001, 1'b0, 1'b0, mk(16'h0002, 0, 0, 0, 0));
    wait_outs(base + 1);

    // WIDTH=4 and WIDTH=64 instances; flags packed as {cout, ovf, gout, pout}.
    narrow_wide_beat(4'hF, 4'h1, 1'b0, 4'h0, 4'b1010,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'b1010);
    narrow_wide_beat(4'h3, 4'h5, 1'b1, 4'hE, 4'b0000,
                     64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 4'b0100);

    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor. It is the multi-level successor of the team's 4-bit group generate/propagate (gp4) cell. It builds a hierarchical lookahead tree of gp4 cells over WIDTH bits, registers it as a 3-stage pipeline, and exposes valid/ready handshakes on both sides. It sits between the operand staging registers and the ALU writeback path.

Parameters:
- WIDTH, 16: operand width. Legal values are 4, 16 and 64 (powers of 4); any other value is an elaboration error.
- LEVELS, log4(WIDTH): derived, not overridable. Number of gp4 tree levels.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in; ignored when sub=1
- sub  in  1  1: compute a - b as a + ~b + 1
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- cout  out  1  carry-out of MSB
- ovf  out  1  signed overflow
- gout  out  1  top-level group generate
- pout  out  1  top-level group propagate

Behaviour:
- Reset (asynchronous, immediate): all stage valid bits are 0, and out_valid, sum, cout, ovf, gout and pout are 0. in_ready is 1 one cycle after reset deasserts.
- Global advance: adv = !out_valid | out_ready. in_ready = adv. All three stage registers load only when adv=1.
- A beat is accepted when in_valid & in_ready. A result is consumed when out_valid & out_ready.
- Stage 1 (S1): b_eff = sub ? ~b : b, and c0 = sub ? 1 : cin. Per-bit g = a & b_eff, p = a ^ b_eff. S1 registers g, p, c0, a[MSB] and b_eff[MSB].
- Stage 2 (S2): the gp4 tree over LEVELS levels produces all WIDTH carries, c[i] for i = 1..WIDTH. A gp4 cell has inputs gin[3:0], pin[3:0], cin and outputs gout, pout, cout[2:0]. Level-k group carries feed back down the tree as cin of the child cells. S2 registers the carry vector, p, the top-level gout/pout, and the MSB bits.
- Stage 3 (S3):
  - sum[i] = p[i] ^ c[i]
  - cout = c[WIDTH]
  - ovf = (a[MSB] == b_eff[MSB]) & (sum[MSB] != a[MSB])
  - S3 registers drive the outputs directly.
- Latency: exactly 3 cycles from acceptance to out_valid when unstalled. Throughput is 1 beat per cycle.
- Backpressure: while out_valid=1 and out_ready=0, every stage holds and all outputs are stable, bit-exact. in_ready=0 in the same cycle (combinational from out_ready). No beat is lost or duplicated, and order is preserved.
- Bubbles: stage valid bits propagate with the data. Bubbles advance freely because adv=1 whenever out_valid=0.
- gout/pout describe the full-width operands, independent of cin. They equal the gp4 definition applied recursively: pout = &p, gout = generate of the MSB group chain.
- sub=1 with b=0: result is a, cout=1.
- Reset mid-operation flushes all in-flight beats. No output is produced for them.
- Outputs are 0 in any cycle where out_valid=0 only after reset. Otherwise they hold the last result; the bench checks them only when out_valid=1.

Decomposition:
- Package cla_pkg holds:
  - localparam function clog4()
  - the legality check for WIDTH
  - stage index constants S1/S2/S3
- Sub-module: the existing gp4 cell, instantiated WIDTH/4 + WIDTH/16 + ... times by a generate loop inside a new sub-module cla_tree, parametrised on WIDTH. cla_tree is purely combinational. All registers live in cla_pipe_adder.

Test Plan:
- WIDTH=16, add a=0xFFFF, b=0x0001, cin=0 -> 3 cycles later: sum=0x0000, cout=1, ovf=0, gout=1, pout=0.
- WIDTH=16, add a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Then a=0x1234, b=0x0000, cin=1 -> sum=0x1235, cout=0, ovf=0.
- WIDTH=16, sub a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0. Sub a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Stream 8 back-to-back random beats with out_ready=1 -> out_valid high for 8 consecutive cycles starting cycle 3, results in order, matching a reference model.
- Stream 4 beats, hold out_ready=0 for 5 cycles after the first out_valid -> in_ready=0 during hold, sum/cout stable. After release, all 4 results arrive in order with no duplicates.
- Assert rst for 1 cycle while 2 beats are in flight -> out_valid=0 immediately, no stale result ever appears. Repeat the directed cases at WIDTH=4 (a=0xF, b=0x1 -> sum=0x0, cout=1) and WIDTH=64 (all-ones + 1 -> sum=0, cout=1).
